aes256_key_sched_ctrl: RTL and testbench

- Iterative AES-256 key-schedule controller for the AES-256-CTR core.
- Accepts a 256-bit cipher key through a valid/ready handshake, then generates words w8..w59 at one word per cycle using a single shared 4-byte SubWord unit.
- Stores all 15 round keys in an internal word file.
- Serves round keys to the cipher round engine through an indexed request/response port with one-cycle read latency.

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_sbox.sv | 46 ++++
 rtl/aes256_key_sched_ctrl.sv | 142 ++++++++++++++
 tb/tb_aes256_key_sched_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule constants, controller state encoding
// and the small word helpers used by the key expansion.
package aes_pkg;

    localparam int NK        = 8;
    localparam int NR        = 14;
    localparam int NUM_WORDS = 4 * (NR + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    // Round constant for word index i is selected by i/8, which is 1..7 for AES-256.
    function automatic logic [7:0] rcon(input logic [2:0] idx);
        logic [7:0] value;
        case (idx)
            3'd1:    value = 8'h01;
            3'd2:    value = 8'h02;
            3'd3:    value = 8'h04;
            3'd4:    value = 8'h08;
            3'd5:    value = 8'h10;
            3'd6:    value = 8'h20;
            3'd7:    value = 8'h40;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    // Cyclic left rotation by one byte: (a,b,c,d) -> (b,c,d,a).
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box for one byte, computed as the GF(2^8) multiplicative
// inverse followed by the affine transform.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Multiply modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] shifted;
        prod    = 8'h00;
        shifted = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                prod = prod ^ shifted;
            end
            shifted = shifted[7] ? ({shifted[6:0], 1'b0} ^ 8'h1b) : {shifted[6:0], 1'b0};
        end
        return prod;
    endfunction

    // x^254 equals x^-1 for nonzero x and yields 0 for 0, as the S-box needs.
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] power;
        logic [7:0] acc;
        power = x;
        acc   = 8'h01;
        for (int k = 0; k < 7; k++) begin
            power = gfMul(power, power);
            acc   = gfMul(acc, power);
        end
        return acc;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Pure combinational lookup; no state is held here.
    always_comb begin
        out_o = affine(gfInv(in_i));
    end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Iterative AES-256 key schedule: loads w0..w7 from the cipher key, derives
// w8..w59 one word per cycle through a single shared SubWord, and serves
// 128-bit round keys through a registered indexed read port.
module aes256_key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [255:0] key,
    output logic         key_ready,
    input  logic         clr,
    output logic         busy,
    output logic         keys_ready,
    input  logic         rk_req,
    input  logic [3:0]   rk_idx,
    output logic         rk_valid,
    output logic [127:0] rk_data,
    output logic         rk_err
);

    ks_state_t     state_q, state_d;
    logic [5:0]    wordIdx_q, wordIdx_d;
    logic [31:0]   lastWord_q, lastWord_d;
    logic [31:0]   wordFile_q [0:NUM_WORDS-1];

    logic          flush;
    logic          acceptKey;
    logic [31:0]   sboxIn;
    logic [31:0]   subWord;
    logic [31:0]   tWord;
    logic [31:0]   newWord;
    logic [5:0]    rdBase;
    logic          rdOk;

    logic          rkValid_q;
    logic          rkErr_q;
    logic [127:0]  rkData_q;

    assign flush      = rst | clr;
    assign key_ready  = (state_q == IDLE) || (state_q == DONE);
    assign busy       = (state_q == EXPAND);
    assign keys_ready = (state_q == DONE);
    assign acceptKey  = key_valid & key_ready;

    assign rdBase     = {rk_idx, 2'b00};
    assign rdOk       = keys_ready && (rk_idx <= 4'd14);

    assign rk_valid   = rkValid_q;
    assign rk_err     = rkErr_q;
    assign rk_data    = rkData_q;

    // Only the i%8==0 step rotates before substitution.
    assign sboxIn = (wordIdx_q[2:0] == 3'd0) ? rot_word(lastWord_q) : lastWord_q;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (sboxIn[8*g +: 8]),
            .out_o (subWord[8*g +: 8])
        );
    end

    // Select the schedule temp word t from the position of i within its group of eight.
    always_comb begin
        tWord = lastWord_q;
        case (wordIdx_q[2:0])
            3'd0:    tWord = subWord ^ {rcon(wordIdx_q[5:3]), 24'h000000};
            3'd4:    tWord = subWord;
            default: tWord = lastWord_q;
        endcase
        newWord = wordFile_q[wordIdx_q - 6'd8] ^ tWord;
    end

    // Next-state logic: a key handshake always restarts expansion; w59 finishes it.
    always_comb begin
        state_d    = state_q;
        wordIdx_d  = wordIdx_q;
        lastWord_d = lastWord_q;
        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    state_d    = EXPAND;
                    wordIdx_d  = 6'd8;
                    lastWord_d = key[31:0];
                end
            end
            EXPAND: begin
                lastWord_d = newWord;
                wordIdx_d  = wordIdx_q + 6'd1;
                if (wordIdx_q == 6'd59) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; rst and clr both return to IDLE and hide the word file.
    always_ff @(posedge clk) begin
        if (flush) begin
            state_q    <= IDLE;
            wordIdx_q  <= 6'd0;
            lastWord_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            wordIdx_q  <= wordIdx_d;
            lastWord_q <= lastWord_d;
        end
    end

    // Word file is never cleared; it only becomes readable again once DONE is reached.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (acceptKey) begin
                for (int k = 0; k < NK; k++) begin
                    wordFile_q[k] <= key[255 - 32*k -: 32];
                end
            end else if (state_q == EXPAND) begin
                wordFile_q[wordIdx_q] <= newWord;
            end
        end
    end

    // Registered read port sampling pre-edge contents, so a same-cycle re-key returns old keys.
    always_ff @(posedge clk) begin
        if (flush) begin
            rkValid_q <= 1'b0;
            rkErr_q   <= 1'b0;
            rkData_q  <= 128'h0;
        end else begin
            rkValid_q <= rk_req & rdOk;
            rkErr_q   <= rk_req & ~rdOk;
            if (rk_req && rdOk) begin
                rkData_q <= {wordFile_q[rdBase], wordFile_q[rdBase + 6'd1],
                             wordFile_q[rdBase + 6'd2], wordFile_q[rdBase + 6'd3]};
            end
        end
    end

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Directed testbench for aes256_key_sched_ctrl using the FIPS-197 C.3 and
// A.3 AES-256 keys and their published round keys.
module tb_aes256_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [255:0] key;
    logic         key_ready;
    logic         clr;
    logic         busy;
    logic         keys_ready;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_err;

    int checks = 0;
    int errors = 0;
    int cyc;

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] c3Keys [0:14];

    aes256_key_sched_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .clr        (clr),
        .busy       (busy),
        .keys_ready (keys_ready),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_valid   (rk_valid),
        .rk_data    (rk_data),
        .rk_err     (rk_err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [255:0] k);
        key_valid = 1'b1;
        key       = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic waitKeysReady(output int n);
        n = 1;
        while (!keys_ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic readRoundKey(input string tag, input logic [3:0] idx,
                                input logic [127:0] expected);
        rk_req = 1'b1;
        rk_idx = idx;
        tick();
        rk_req = 1'b0;
        checkOutput({tag, "_valid"}, {127'h0, rk_valid}, 128'd1);
        checkOutput(tag, rk_data, expected);
    endtask

    // Main directed sequence.
    initial begin
        c3Keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        c3Keys[1]  = 128'h101112131415161718191a1b1c1d1e1f;
        c3Keys[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
        c3Keys[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
        c3Keys[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
        c3Keys[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
        c3Keys[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
        c3Keys[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
        c3Keys[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
        c3Keys[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
        c3Keys[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
        c3Keys[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
        c3Keys[12] = 128'h2541fe719bf500258813bbd55a721c0a;
        c3Keys[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
        c3Keys[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;

        rst       = 1'b1;
        clr       = 1'b0;
        key_valid = 1'b0;
        key       = '0;
        rk_req    = 1'b0;
        rk_idx    = 4'd0;
        tick();
        tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_key_ready",  {127'h0, key_ready},  128'd1);
        checkOutput("rst_busy",       {127'h0, busy},       128'd0);
        checkOutput("rst_keys_ready", {127'h0, keys_ready}, 128'd0);
        checkOutput("rst_rk_valid",   {127'h0, rk_valid},   128'd0);
        checkOutput("rst_rk_err",     {127'h0, rk_err},     128'd0);
        checkOutput("rst_rk_data",    rk_data,              128'd0);

        $display("[TB] C.3 key expansion");
        applyStimulus(KEY_C3);
        checkOutput("c3_busy",      {127'h0, busy},       128'd1);
        checkOutput("c3_key_ready", {127'h0, key_ready},  128'd0);
        waitKeysReady(cyc);
        checkOutput("c3_latency", 128'(cyc), 128'd53);
        checkOutput("c3_done_key_ready", {127'h0, key_ready}, 128'd1);
        checkOutput("c3_done_busy",      {127'h0, busy},      128'd0);
        readRoundKey("c3_rk0",  4'd0,  128'h000102030405060708090a0b0c0d0e0f);
        readRoundKey("c3_rk2",  4'd2,  128'ha573c29fa176c498a97fce93a572c09c);
        readRoundKey("c3_rk14", 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        $display("[TB] back-to-back reads");
        rk_req = 1'b1;
        rk_idx = 4'd0;
        for (int i = 0; i < 15; i++) begin
            tick();
            rk_idx = (i < 14) ? 4'(i + 1) : 4'd15;
            checkOutput($sformatf("b2b_valid_%0d", i), {127'h0, rk_valid}, 128'd1);
            checkOutput($sformatf("b2b_data_%0d", i), rk_data, c3Keys[i]);
        end
        tick();
        rk_req = 1'b0;
        checkOutput("idx15_err",   {127'h0, rk_err},   128'd1);
        checkOutput("idx15_valid", {127'h0, rk_valid}, 128'd0);
        checkOutput("idx15_data",  rk_data,            c3Keys[14]);
        tick();
        checkOutput("idx15_err_pulse", {127'h0, rk_err}, 128'd0);

        $display("[TB] read and held key_valid during expansion");
        key_valid = 1'b1;
        key       = KEY_C3;
        tick();
        cyc = 1;
        while (!keys_ready && cyc < 200) begin
            if (cyc == 5) begin
                rk_req = 1'b1;
                rk_idx = 4'd0;
            end
            tick();
            cyc++;
            if (cyc == 6) begin
                rk_req = 1'b0;
                checkOutput("exp_rk_err",    {127'h0, rk_err},    128'd1);
                checkOutput("exp_rk_valid",  {127'h0, rk_valid},  128'd0);
                checkOutput("exp_rk_data",   rk_data,             c3Keys[14]);
                checkOutput("exp_key_ready", {127'h0, key_ready}, 128'd0);
                checkOutput("exp_busy",      {127'h0, busy},      128'd1);
            end
        end
        key_valid = 1'b0;
        checkOutput("held_latency", 128'(cyc), 128'd53);

        $display("[TB] clr during expansion");
        applyStimulus(KEY_C3);
        for (int i = 1; i < 20; i++) begin
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checkOutput("clr_busy",       {127'h0, busy},       128'd0);
        checkOutput("clr_keys_ready", {127'h0, keys_ready}, 128'd0);
        checkOutput("clr_key_ready",  {127'h0, key_ready},  128'd1);
        rk_req = 1'b1;
        rk_idx = 4'd2;
        tick();
        rk_req = 1'b0;
        checkOutput("clr_rk_err",   {127'h0, rk_err},   128'd1);
        checkOutput("clr_rk_valid", {127'h0, rk_valid}, 128'd0);
        applyStimulus(KEY_C3);
        waitKeysReady(cyc);
        checkOutput("rekey_latency", 128'(cyc), 128'd53);
        readRoundKey("rekey_rk2",  4'd2,  c3Keys[2]);
        readRoundKey("rekey_rk0",  4'd0,  c3Keys[0]);

        $display("[TB] re-key in DONE with simultaneous read");
        key_valid = 1'b1;
        key       = KEY_A3;
        rk_req    = 1'b1;
        rk_idx    = 4'd14;
        tick();
        key_valid = 1'b0;
        rk_req    = 1'b0;
        checkOutput("sim_rk_valid",   {127'h0, rk_valid},   128'd1);
        checkOutput("sim_rk_data",    rk_data,              c3Keys[14]);
        checkOutput("sim_keys_ready", {127'h0, keys_ready}, 128'd0);
        checkOutput("sim_busy",       {127'h0, busy},       128'd1);
        waitKeysReady(cyc);
        checkOutput("a3_latency", 128'(cyc), 128'd53);
        readRoundKey("a3_rk0",  4'd0,  128'h603deb1015ca71be2b73aef0857d7781);
        readRoundKey("a3_rk2",  4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde);
        readRoundKey("a3_rk3",  4'd3,  128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        readRoundKey("a3_rk14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);

        $display("[TB] rst during DONE");
        rst    = 1'b1;
        rk_req = 1'b1;
        rk_idx = 4'd3;
        tick();
        rst    = 1'b0;
        rk_req = 1'b0;
        checkOutput("drst_key_ready",  {127'h0, key_ready},  128'd1);
        checkOutput("drst_busy",       {127'h0, busy},       128'd0);
        checkOutput("drst_keys_ready", {127'h0, keys_ready}, 128'd0);
        checkOutput("drst_rk_valid",   {127'h0, rk_valid},   128'd0);
        checkOutput("drst_rk_err",     {127'h0, rk_err},     128'd0);
        checkOutput("drst_rk_data",    rk_data,              128'd0);
        tick();
        checkOutput("drst_idle_hold", {127'h0, key_ready}, 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
